cordic_iter_stream: RTL and testbench
=====================================

Name: cordic_iter_stream

Overview:
- Parametrised, iterative CORDIC engine with valid/ready handshakes on both sides.
- Replaces the fixed 16-bit, rotation-only core that sits between the theta FIFO and the sin/cos FIFOs.
- Adds two modes: rotation (rotate (x,y) by z) and vectoring (magnitude/angle of (x,y)).
- Adds configurable width and iteration count, and true backpressure, so downstream FIFOs never overflow.

Parameters:
- DATA_WIDTH, 16: width of all data ports. Signed two's complement, FRAC = DATA_WIDTH-3 fractional bits (16 -> Q3.13, 1.0 = 8192, pi = 25736).
- ITERATIONS, 14: number of micro-rotations, 1 per cycle. Legal range 1..DATA_WIDTH-1; elaboration error otherwise.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept an operand this cycle
- in_mode  in  1  0 = rotation, 1 = vectoring
- in_x  in  DATA_WIDTH  x operand
- in_y  in  DATA_WIDTH  y operand
- in_z  in  DATA_WIDTH  angle operand in radians (rotation mode only; ignored in vectoring)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_x  out  DATA_WIDTH  result x (rotation: x'; vectoring: gain-scaled magnitude)
- out_y  out  DATA_WIDTH  result y (rotation: y'; vectoring: residual, approximately 0)
- out_z  out  DATA_WIDTH  result angle (rotation: residual, approximately 0; vectoring: atan2(y,x))
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any time, including mid-run or while holding a result):
  - state = IDLE; iteration counter = 0; out_valid = 0; out_x/out_y/out_z = 0; busy = 0.
  - In-flight operand is discarded.
  - in_ready = 1 once reset is deasserted.
- FSM states IDLE, RUN, DONE:
  - IDLE -> RUN on accept (in_valid and in_ready).
  - RUN -> DONE on the edge executing iteration ITERATIONS-1.
  - DONE -> IDLE on out_valid and out_ready with no new accept.
  - DONE -> RUN on out_valid, out_ready and a new accept in the same edge (back-to-back).
- Handshakes:
  - in_ready = (state == IDLE) or (state == DONE and out_ready). Combinational from state and out_ready only; never from in_valid.
  - out_valid = (state == DONE). out_x/out_y/out_z stay stable while out_valid=1 and out_ready=0.
- Accept edge: latch mode and load internal registers after pre-processing.
  - Internal x/y: DATA_WIDTH+2 bits. Internal z: DATA_WIDTH+1 bits.
  - Rotation:
    - Wrap z once into [-pi,pi] (z > pi: subtract 2*pi; z < -pi: add 2*pi).
    - Then fold: z > pi/2 -> z -= pi, negate x and y. z < -pi/2 -> z += pi, negate x and y.
  - Vectoring:
    - z = 0.
    - If x < 0: negate x and y, and set z = +pi if y >= 0, else -pi.
- RUN, iteration i on each edge (i = 0..ITERATIONS-1):
  - d = sign(z) in rotation; d = -sign(y) in vectoring; 0 counts as positive.
  - x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*atan_tab[i].
  - Arithmetic shifts.
- atan_tab[i] = round(atan(2^-i) * 2^FRAC), computed in an elaboration-time constant function; no hand-entered ROM.
- No gain compensation. Results carry gain An (about 1.6468 for large N). For sin/cos, the caller supplies x = round(2^FRAC / An) (4975 at default), y = 0.
- Output on the RUN->DONE edge:
  - Drop 2 guard bits by truncation (see Optional Feature).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Latency: out_valid rises exactly ITERATIONS+1 edges after the accept edge. Throughput: 1 result per ITERATIONS+1 cycles under full out_ready.
- in_valid while in RUN: ignored (in_ready = 0). Operand must be held by the producer.

Optional Feature:
- Macro: CORDIC_ROUND_EN.
- Defined: output reduction is round-half-up. Add 2'b10 at the guard position before dropping the guard bits, then saturate. Rounding carry into the sign is caught by saturation.
- Undefined: plain truncation (floor) of the guard bits.
- Latency and handshakes are identical in both builds.

Test Plan:
- Reset, then rotation x=4975, y=0, z=0 -> out_x = 8192 +/-2, out_y = 0 +/-2. out_valid rises 15 edges after accept.
- Rotation x=4975, y=0, z=12868 (pi/2) -> out_x = 0 +/-2, out_y = 8192 +/-2. Rotation z=25736 (pi) -> out_x = -8192 +/-2, out_y = 0 +/-2 (fold path).
- Rotation z=-30000 (< -pi, wrap path) -> result equals z=21472 within +/-2 LSB.
- Vectoring x=4915, y=6554 -> out_x = 13490 +/-3, out_z = 7596 +/-2. Vectoring x=-4915, y=0 -> out_x = 8094 +/-3, out_z = 25736 +/-2.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0. Then raise out_ready with in_valid=1 -> same-edge release and accept, next out_valid after 15 edges.
- Assert reset at iteration 5 of a run -> out_valid=0, outputs 0 immediately (async). Next operand after reset completes with correct values. Run the suite with and without CORDIC_ROUND_EN; results differ by at most 1 LSB.

Source files
------------

// File: rtl/cordic_iter_stream.sv
// Iterative CORDIC engine (rotation / vectoring) with valid/ready on both sides.
// Optional build macro CORDIC_ROUND_EN: round-half-up on output reduction instead of truncation.
module cordic_iter_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ITERATIONS = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_y,
  input  logic [DATA_WIDTH-1:0] in_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic                  busy
);

  localparam int W    = DATA_WIDTH;
  localparam int IW   = W + 2;
  localparam int ZW   = W + 1;
  localparam int FRAC = W - 3;
  localparam int CW   = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  if (ITERATIONS < 1 || ITERATIONS > DATA_WIDTH - 1) begin : g_bad_iterations
    $error("cordic_iter_stream: ITERATIONS must lie in 1..DATA_WIDTH-1");
  end

  function automatic real atan_series(input real t);
    real term;
    real sum;
    real t2;
    sum  = 0.0;
    term = t;
    t2   = t * t;
    for (int k = 0; k < 60; k++) begin
      if (k % 2 == 0) begin
        sum = sum + term / $itor(2 * k + 1);
      end else begin
        sum = sum - term / $itor(2 * k + 1);
      end
      term = term * t2;
    end
    return sum;
  endfunction

  // atan(1) via Machin's formula keeps every series argument well below 1
  function automatic real atan_pow2(input int i);
    real t;
    if (i == 0) begin
      return 4.0 * atan_series(0.2) - atan_series(1.0 / 239.0);
    end else begin
      t = 1.0;
      for (int k = 0; k < i; k++) begin
        t = t / 2.0;
      end
      return atan_series(t);
    end
  endfunction

  function automatic int to_fix(input real v);
    real s;
    s = 1.0;
    for (int k = 0; k < FRAC; k++) begin
      s = s * 2.0;
    end
    return $rtoi(v * s + 0.5);
  endfunction

  localparam logic signed [ZW-1:0] PI_Z       = ZW'(to_fix(4.0 * atan_pow2(0)));
  localparam logic signed [ZW-1:0] NEG_PI_Z   = -PI_Z;
  localparam logic signed [ZW-1:0] HALF_PI_Z  = ZW'(to_fix(2.0 * atan_pow2(0)));
  localparam logic signed [ZW-1:0] NEG_HALF_Z = -HALF_PI_Z;
  localparam logic signed [ZW-1:0] TWO_PI_Z   = ZW'(to_fix(8.0 * atan_pow2(0)));
  localparam logic [CW-1:0]        LAST_ITER  = CW'(ITERATIONS - 1);

  logic signed [ZW-1:0] atan_tab_s [ITERATIONS];

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    localparam logic signed [ZW-1:0] ATAN_G = ZW'(to_fix(atan_pow2(g)));
    assign atan_tab_s[g] = ATAN_G;
  end

  function automatic logic [W-1:0] sat_w1(input logic signed [W:0] v);
    if (v[W] != v[W-1]) begin
      return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      return v[W-1:0];
    end
  endfunction

  // Drops the two guard bits; the extra top bit lets a rounding carry reach saturation
  function automatic logic [W-1:0] reduce_xy(input logic signed [IW-1:0] v);
    logic signed [IW:0] t;
`ifdef CORDIC_ROUND_EN
    t = {v[IW-1], v} + {{(IW-1){1'b0}}, 2'b10};
`else
    t = {v[IW-1], v};
`endif
    return sat_w1(t[IW:2]);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [CW-1:0]        iter_r, iter_nxt_s;
  logic                 mode_r, mode_nxt_s;
  logic signed [IW-1:0] x_r, y_r, x_nxt_s, y_nxt_s;
  logic signed [ZW-1:0] z_r, z_nxt_s;
  logic [W-1:0]         out_x_r, out_y_r, out_z_r;
  logic [W-1:0]         out_x_nxt_s, out_y_nxt_s, out_z_nxt_s;
  logic                 in_ready_s, accept_s;
  logic signed [IW-1:0] pre_x_s, pre_y_s, x0_s, y0_s;
  logic signed [ZW-1:0] pre_z_s, z0_s, zw_s;
  logic signed [IW-1:0] x_it_s, y_it_s;
  logic signed [ZW-1:0] z_it_s;
  logic                 d_pos_s;

  assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign in_ready   = in_ready_s;
  assign out_valid  = (state_r == ST_DONE);
  assign busy       = (state_r != ST_IDLE);
  assign out_x      = out_x_r;
  assign out_y      = out_y_r;
  assign out_z      = out_z_r;

  // Operand pre-processing: angle wrap and half-plane fold (rotation), left half-plane flip (vectoring)
  always_comb begin
    x0_s    = $signed({in_x, 2'b00});
    y0_s    = $signed({in_y, 2'b00});
    z0_s    = $signed({in_z[W-1], in_z});
    zw_s    = z0_s;
    pre_x_s = x0_s;
    pre_y_s = y0_s;
    pre_z_s = z0_s;
    if (in_mode) begin
      if (in_x[W-1]) begin
        pre_x_s = -x0_s;
        pre_y_s = -y0_s;
        pre_z_s = in_y[W-1] ? NEG_PI_Z : PI_Z;
      end else begin
        pre_z_s = '0;
      end
    end else begin
      if (z0_s > PI_Z) begin
        zw_s = z0_s - TWO_PI_Z;
      end else if (z0_s < NEG_PI_Z) begin
        zw_s = z0_s + TWO_PI_Z;
      end else begin
        zw_s = z0_s;
      end
      if (zw_s > HALF_PI_Z) begin
        pre_z_s = zw_s - PI_Z;
        pre_x_s = -x0_s;
        pre_y_s = -y0_s;
      end else if (zw_s < NEG_HALF_Z) begin
        pre_z_s = zw_s + PI_Z;
        pre_x_s = -x0_s;
        pre_y_s = -y0_s;
      end else begin
        pre_z_s = zw_s;
      end
    end
  end

  // One micro-rotation; a zero steering value counts as positive
  always_comb begin
    d_pos_s = mode_r ? y_r[IW-1] : ~z_r[ZW-1];
    if (d_pos_s) begin
      x_it_s = x_r - (y_r >>> iter_r);
      y_it_s = y_r + (x_r >>> iter_r);
      z_it_s = z_r - atan_tab_s[iter_r];
    end else begin
      x_it_s = x_r + (y_r >>> iter_r);
      y_it_s = y_r - (x_r >>> iter_r);
      z_it_s = z_r + atan_tab_s[iter_r];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt_s = state_r;
    iter_nxt_s  = iter_r;
    mode_nxt_s  = mode_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    z_nxt_s     = z_r;
    out_x_nxt_s = out_x_r;
    out_y_nxt_s = out_y_r;
    out_z_nxt_s = out_z_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        x_nxt_s = x_it_s;
        y_nxt_s = y_it_s;
        z_nxt_s = z_it_s;
        if (iter_r == LAST_ITER) begin
          state_nxt_s = ST_DONE;
          iter_nxt_s  = '0;
          out_x_nxt_s = reduce_xy(x_it_s);
          out_y_nxt_s = reduce_xy(y_it_s);
          out_z_nxt_s = sat_w1(z_it_s);
        end else begin
          iter_nxt_s = iter_r + CW'(1);
        end
      end
      ST_DONE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (accept_s) begin
      iter_nxt_s = '0;
      mode_nxt_s = in_mode;
      x_nxt_s    = pre_x_s;
      y_nxt_s    = pre_y_s;
      z_nxt_s    = pre_z_s;
    end else begin
      mode_nxt_s = mode_nxt_s;
    end
  end

  // State and datapath registers; reset discards any in-flight operand
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      iter_r  <= '0;
      mode_r  <= 1'b0;
      x_r     <= '0;
      y_r     <= '0;
      z_r     <= '0;
      out_x_r <= '0;
      out_y_r <= '0;
      out_z_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      iter_r  <= iter_nxt_s;
      mode_r  <= mode_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      z_r     <= z_nxt_s;
      out_x_r <= out_x_nxt_s;
      out_y_r <= out_y_nxt_s;
      out_z_r <= out_z_nxt_s;
    end
  end

endmodule

// File: tb/tb_cordic_iter_stream.sv
// Directed self-checking bench for cordic_iter_stream (default 16-bit Q3.13, 14 iterations).
module tb_cordic_iter_stream;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic               in_mode;
  logic [15:0]        in_x, in_y, in_z;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_x, out_y, out_z;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_iter_stream #(.DATA_WIDTH(16), .ITERATIONS(14)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .busy(busy)
  );

  // Latency counts the accept edge as edge 1; results are taken on the first negedge with out_valid
  task automatic run_op(input logic mode, input int x, input int y, input int z,
                        output int lat, output int ox, output int oy, output int oz);
    @(negedge clk);
    in_mode = mode; in_x = 16'(x); in_y = 16'(y); in_z = 16'(z);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    ox = int'(out_x); oy = int'(out_y); oz = int'(out_z);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
    in_x = 16'd0; in_y = 16'd0; in_z = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if ({out_x, out_y, out_z} !== 48'd0) begin
      errors++; $display("FAIL reset_outputs: got %0d %0d %0d want 0 0 0", out_x, out_y, out_z);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rotation();
    int zt [5];
    int ex [5];
    int ey [5];
    int tl [5];
    int lat, ox, oy, oz;
    zt = '{0, 12868, 25736, -30000, 21472};
    ex = '{8192, 0, -8192, -7107, -7107};
    ey = '{0, 8192, 0, 4074, 4074};
    tl = '{2, 2, 2, 3, 3};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, 4975, 0, zt[i], lat, ox, oy, oz);
      checks++;
      if (lat != 15) begin errors++; $display("FAIL rot_latency[%0d]: got %0d want 15", i, lat); end
      checks++;
      if ((ox - ex[i]) > tl[i] || (ex[i] - ox) > tl[i]) begin
        errors++; $display("FAIL rot_x[%0d]: got %0d want %0d +/-%0d", i, ox, ex[i], tl[i]);
      end
      checks++;
      if ((oy - ey[i]) > tl[i] || (ey[i] - oy) > tl[i]) begin
        errors++; $display("FAIL rot_y[%0d]: got %0d want %0d +/-%0d", i, oy, ey[i], tl[i]);
      end
      checks++;
      if (oz > 2 || oz < -2) begin
        errors++; $display("FAIL rot_z_residual[%0d]: got %0d want 0 +/-2", i, oz);
      end
    end
  endtask

  task automatic test_vectoring();
    int xt [2];
    int yt [2];
    int ex [2];
    int ez [2];
    int lat, ox, oy, oz;
    xt = '{4915, -4915};
    yt = '{6554, 0};
    ex = '{13490, 8094};
    ez = '{7596, 25736};
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, xt[i], yt[i], 0, lat, ox, oy, oz);
      checks++;
      if (lat != 15) begin errors++; $display("FAIL vec_latency[%0d]: got %0d want 15", i, lat); end
      checks++;
      if ((ox - ex[i]) > 3 || (ex[i] - ox) > 3) begin
        errors++; $display("FAIL vec_mag[%0d]: got %0d want %0d +/-3", i, ox, ex[i]);
      end
      checks++;
      if ((oz - ez[i]) > 2 || (ez[i] - oz) > 2) begin
        errors++; $display("FAIL vec_angle[%0d]: got %0d want %0d +/-2", i, oz, ez[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cx, cy, cz, lat;
    @(negedge clk);
    out_ready = 1'b0;
    in_mode = 1'b0; in_x = 16'd4975; in_y = 16'd0; in_z = 16'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    cx = int'(out_x); cy = int'(out_y); cz = int'(out_z);
    checks++;
    if ((cx - 8192) > 2 || (8192 - cx) > 2) begin
      errors++; $display("FAIL bp_result_x: got %0d want 8192 +/-2", cx);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_x) != cx || int'(out_y) != cy || int'(out_z) != cz) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b %0d %0d %0d want v=1 rdy=0 %0d %0d %0d",
                 i, out_valid, in_ready, out_x, out_y, out_z, cx, cy, cz);
      end
    end
    in_z = 16'd12868; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_same_edge: got v=%b busy=%b want v=0 busy=1", out_valid, busy);
    end
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    checks++;
    if (lat != 15) begin errors++; $display("FAIL bp_latency: got %0d want 15", lat); end
    checks++;
    if (int'(out_x) > 2 || int'(out_x) < -2 || (int'(out_y) - 8192) > 2 || (8192 - int'(out_y)) > 2) begin
      errors++; $display("FAIL bp_result2: got %0d %0d want 0 8192 +/-2", out_x, out_y);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midrun();
    int lat, ox, oy, oz;
    @(negedge clk);
    in_mode = 1'b0; in_x = 16'd4975; in_y = 16'd0; in_z = 16'd6000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrun_flags: got v=%b busy=%b want 0 0", out_valid, busy);
    end
    checks++;
    if ({out_x, out_y, out_z} !== 48'd0) begin
      errors++; $display("FAIL midrun_outputs: got %0d %0d %0d want 0 0 0", out_x, out_y, out_z);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_in_ready: got %b want 1", in_ready); end
    run_op(1'b0, 4975, 0, -12868, lat, ox, oy, oz);
    checks++;
    if (lat != 15) begin errors++; $display("FAIL midrun_latency: got %0d want 15", lat); end
    checks++;
    if (ox > 2 || ox < -2) begin errors++; $display("FAIL midrun_x: got %0d want 0 +/-2", ox); end
    checks++;
    if ((oy + 8192) > 2 || (-8192 - oy) > 2) begin
      errors++; $display("FAIL midrun_y: got %0d want -8192 +/-2", oy);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_vectoring();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
